stopwatch_ctrl: RTL and testbench

- Timekeeping controller behind the VGA HH:MM:SS.mmm stopwatch display.
- Turns single-cycle button pulses into run, pause, lap and clear behaviour, and keeps a BCD time count at 1 ms resolution.
- Feeds the nine BCD digits the display renderer decodes into segment regions.
- Sits between the debounce/pulse logic and the VGA segment renderer.

---
 rtl/stopwatch_pkg.sv | 33 +++
 rtl/bcd_digit_cnt.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping block and the VGA renderer.
// - FSM state encodings
// - BCD digit width, digit limits and digit positions inside disp_bcd
//   (digit i occupies disp_bcd[4*i +: 4]; digit 0 is ms_o, digit 8 is hr_t)
package stopwatch_pkg;

  localparam int BCD_W       = 4;
  localparam int NUM_DIGITS  = 9;
  // Digits below the hour pair run as a plain carry cascade.
  localparam int NUM_CASCADE = 7;

  localparam logic [BCD_W-1:0] DIG_MAX_10 = 4'd9;
  localparam logic [BCD_W-1:0] DIG_MAX_6  = 4'd5;

  localparam int DIG_MS_O  = 0;
  localparam int DIG_MS_T  = 1;
  localparam int DIG_MS_H  = 2;
  localparam int DIG_SEC_O = 3;
  localparam int DIG_SEC_T = 4;
  localparam int DIG_MIN_O = 5;
  localparam int DIG_MIN_T = 6;
  localparam int DIG_HR_O  = 7;
  localparam int DIG_HR_T  = 8;

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_time_t;

  typedef logic [1:0] sw_state_t;
  localparam sw_state_t ST_IDLE  = 2'd0;
  localparam sw_state_t ST_RUN   = 2'd1;
  localparam sw_state_t ST_LAP   = 2'd2;
  localparam sw_state_t ST_PAUSE = 2'd3;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the time cascade.
// Ports: CLK, RST_BTN (async active-low), clr (sync zero, wins over inc),
//        inc (advance by one), q (digit value), carry (inc while q == MAX).
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIG_MAX_10
) (
  input  logic             CLK,
  input  logic             RST_BTN,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic             at_max;
  logic [BCD_W-1:0] q_nxt;

  assign at_max = (q == MAX);
  assign carry  = inc & at_max;

  always_comb begin
    q_nxt = q;
    if (clr)      q_nxt = '0;
    else if (inc) q_nxt = at_max ? '0 : q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) q <= '0;
    else          q <= q_nxt;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch timekeeping controller.
// Inputs : CLK, RST_BTN (async active-low), start_stop / lap / clear
//          (single-cycle debounced pulses).
// Outputs: disp_bcd (9 BCD digits, hr_t in MSBs; lap snapshot while in LAP),
//          running (RUN or LAP), lap_active (LAP), ms_tick (count advanced),
//          rollover (count wrapped to zero, coincident with ms_tick).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int HOUR_MAX = 23
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [35:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        ms_tick,
  output logic        rollover
);

  localparam int               PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [BCD_W-1:0] HR_MAX_T = BCD_W'(HOUR_MAX / 10);
  localparam logic [BCD_W-1:0] HR_MAX_O = BCD_W'(HOUR_MAX % 10);

  sw_state_t state, state_nxt;
  logic      zero_cnt, snap_ld, counting, tick;
  logic [PW-1:0] presc, presc_nxt;

  logic [NUM_CASCADE-1:0][BCD_W-1:0] dig_q;
  logic [NUM_CASCADE:0]              dig_inc;
  logic [BCD_W-1:0] hr_t, hr_o, hr_t_nxt, hr_o_nxt;
  logic             hr_inc, hr_at_max, wrap;
  bcd_time_t        live, snap;

  // Event priority clear > start_stop > lap, evaluated only among the
  // events that mean something in the current state.
  always_comb begin
    state_nxt = state;
    zero_cnt  = 1'b0;
    snap_ld   = 1'b0;
    case (state)
      ST_IDLE: if (start_stop) state_nxt = ST_RUN;
      ST_RUN, ST_LAP: begin
        if (start_stop) state_nxt = ST_PAUSE;
        else if (lap) begin
          state_nxt = ST_LAP;
          snap_ld   = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_nxt = ST_IDLE;
          zero_cnt  = 1'b1;
        end else if (start_stop) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tick is judged on the current state, so a RUN->PAUSE edge that lands on
  // a tick still applies that increment. PAUSE holds the sub-ms fraction.
  assign counting = (state == ST_RUN) || (state == ST_LAP);
  assign tick     = counting && (presc == PRE_LAST);

  always_comb begin
    presc_nxt = presc;
    if (state == ST_IDLE || zero_cnt) presc_nxt = '0;
    else if (counting)                presc_nxt = tick ? '0 : presc + 1'b1;
  end

  assign dig_inc[0] = tick;

  for (genvar i = 0; i < NUM_CASCADE; i++) begin : g_dig
    localparam logic [BCD_W-1:0] LIM =
      (i == DIG_SEC_T || i == DIG_MIN_T) ? DIG_MAX_6 : DIG_MAX_10;
    bcd_digit_cnt #(.MAX(LIM)) u_dig (
      .CLK    (CLK),
      .RST_BTN(RST_BTN),
      .clr    (zero_cnt),
      .inc    (dig_inc[i]),
      .q      (dig_q[i]),
      .carry  (dig_inc[i+1])
    );
  end

  // Hours wrap on the two-digit value, not per digit (23 -> 00).
  assign hr_inc    = dig_inc[NUM_CASCADE];
  assign hr_at_max = (hr_t == HR_MAX_T) && (hr_o == HR_MAX_O);
  assign wrap      = hr_inc && hr_at_max;

  always_comb begin
    hr_t_nxt = hr_t;
    hr_o_nxt = hr_o;
    if (zero_cnt) begin
      hr_t_nxt = '0;
      hr_o_nxt = '0;
    end else if (hr_inc) begin
      if (hr_at_max) begin
        hr_t_nxt = '0;
        hr_o_nxt = '0;
      end else if (hr_o == DIG_MAX_10) begin
        hr_o_nxt = '0;
        hr_t_nxt = hr_t + 1'b1;
      end else begin
        hr_o_nxt = hr_o + 1'b1;
      end
    end
  end

  always_comb begin
    live = '0;
    for (int i = 0; i < NUM_CASCADE; i++) live[i] = dig_q[i];
    live[DIG_HR_O] = hr_o;
    live[DIG_HR_T] = hr_t;
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state    <= ST_IDLE;
      presc    <= '0;
      hr_t     <= '0;
      hr_o     <= '0;
      snap     <= '0;
      ms_tick  <= 1'b0;
      rollover <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      hr_t     <= hr_t_nxt;
      hr_o     <= hr_o_nxt;
      if (snap_ld) snap <= live;
      ms_tick  <= tick;
      rollover <= wrap;
    end
  end

  // Selected purely from registers: no path from the pulse inputs.
  assign disp_bcd   = (state == ST_LAP) ? snap : live;
  assign running    = counting;
  assign lap_active = (state == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_BTN;
  logic        start_stop, lap, clear;
  logic [35:0] disp_bcd;
  logic        running, lap_active, ms_tick, rollover;

  stopwatch_ctrl #(.TICK_DIV(4), .HOUR_MAX(23)) dut (
    .CLK       (CLK),
    .RST_BTN   (RST_BTN),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .disp_bcd  (disp_bcd),
    .running   (running),
    .lap_active(lap_active),
    .ms_tick   (ms_tick),
    .rollover  (rollover)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [35:0] disp;
    logic        run;
    logic        lap_a;
    logic        roll;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   tick_cnt = 0;
  int   tc_save;

  // Time in milliseconds -> packed BCD display word.
  function automatic logic [35:0] bcd_ms(input int t);
    int h, m, s, ms;
    logic [35:0] r;
    h  = (t / 3600000) % 24;
    m  = (t / 60000) % 60;
    s  = (t / 1000) % 60;
    ms = t % 1000;
    r[35:32] = 4'(h / 10);
    r[31:28] = 4'(h % 10);
    r[27:24] = 4'(m / 10);
    r[23:20] = 4'(m % 10);
    r[19:16] = 4'(s / 10);
    r[15:12] = 4'(s % 10);
    r[11:8]  = 4'(ms / 100);
    r[7:4]   = 4'((ms / 10) % 10);
    r[3:0]   = 4'(ms % 10);
    return r;
  endfunction

  task automatic push(input logic [35:0] d, input logic r, input logic la, input logic ro);
    exp_t e;
    e.disp = d; e.run = r; e.lap_a = la; e.roll = ro;
    exp_q.push_back(e);
  endtask

  task automatic push_live(input int a, input int b);
    for (int k = a; k <= b; k++) push(bcd_ms(k), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_lap(input int a, input int b, input int snap_ms);
    for (int k = a; k <= b; k++) push(bcd_ms(snap_ms), 1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Inputs applied at the current (negedge) point, sampled by the next posedge.
  task automatic pulse(input logic ss, input logic lp, input logic cl);
    start_stop = ss; lap = lp; clear = cl;
    @(negedge CLK);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge CLK); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d ticks outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_disp"},  disp_bcd,   36'h0);
    chk({name, "_run"},   running,    1'b0);
    chk({name, "_lap"},   lap_active, 1'b0);
    chk({name, "_tick"},  ms_tick,    1'b0);
    chk({name, "_roll"},  rollover,   1'b0);
  endtask

  // Monitor: each ms_tick must match the next queued expectation.
  always @(negedge CLK) begin
    if (RST_BTN === 1'b1 && ms_tick === 1'b1) begin
      tick_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tick_unexpected: got tick with disp %h, expected no tick", disp_bcd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({disp_bcd, running, lap_active, rollover} !== mon_e) begin
          errors++;
          $display("FAIL tick_%0d: got disp %h run %b lap %b roll %b, expected disp %h run %b lap %b roll %b",
                   tick_cnt, disp_bcd, running, lap_active, rollover,
                   mon_e.disp, mon_e.run, mon_e.lap_a, mon_e.roll);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_BTN = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    repeat (3) @(negedge CLK);
    #1 chk_all_zero("reset");
    @(negedge CLK); RST_BTN = 1'b1;

    // Run 1 s, then lap twice.
    push_live(1, 1234);
    @(negedge CLK); pulse(1, 0, 0);
    repeat (4000) @(negedge CLK);
    #1;
    chk("run_1s_disp", disp_bcd, bcd_ms(1000));
    chk("run_1s_ticks", 36'(tick_cnt), 36'd1000);
    chk("run_1s_running", running, 1'b1);
    push_lap(1235, 1334, 1234);
    repeat (937) @(negedge CLK);
    pulse(0, 1, 0);
    #1;
    chk("lap1_disp", disp_bcd, bcd_ms(1234));
    chk("lap1_active", lap_active, 1'b1);
    push_lap(1335, 1340, 1334);
    repeat (399) @(negedge CLK);
    pulse(0, 1, 0);
    #1;
    chk("lap2_disp", disp_bcd, bcd_ms(1334));
    chk("lap2_active", lap_active, 1'b1);
    drain(100);

    // Async reset mid-LAP, away from any clock edge.
    #2 RST_BTN = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(negedge CLK);
    RST_BTN = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    chk("post_rst_idle_run", running, 1'b0);
    chk("post_rst_idle_disp", disp_bcd, 36'h0);

    // Pause at .005 with prescaler at 2; resume -> tick 2 cycles later.
    push_live(1, 5);
    @(negedge CLK); pulse(1, 0, 0);
    repeat (21) @(negedge CLK);
    pulse(1, 0, 0);
    #1;
    chk("pause_running", running, 1'b0);
    chk("pause_disp", disp_bcd, bcd_ms(5));
    tc_save = tick_cnt;
    repeat (100) @(negedge CLK);
    #1;
    chk("paused_hold_disp", disp_bcd, bcd_ms(5));
    chk("paused_no_ticks", 36'(tick_cnt), 36'(tc_save));
    push_live(6, 6);
    pulse(1, 0, 0);
    @(negedge CLK); #1;
    chk("resume_c1_tick", ms_tick, 1'b0);
    chk("resume_c1_disp", disp_bcd, bcd_ms(5));
    @(negedge CLK); #1;
    chk("resume_c2_tick", ms_tick, 1'b1);
    chk("resume_c2_disp", disp_bcd, bcd_ms(6));

    // start_stop on a tick edge: increment still lands, now in PAUSE.
    push(bcd_ms(7), 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    pulse(1, 0, 0);
    #1 chk("stop_on_tick_disp", disp_bcd, bcd_ms(7));

    // clear + start_stop together in PAUSE: clear wins.
    pulse(1, 0, 1);
    #1;
    chk("clear_pause_disp", disp_bcd, 36'h0);
    chk("clear_pause_run", running, 1'b0);
    repeat (20) @(negedge CLK);
    #1 chk("clear_idle_disp", disp_bcd, 36'h0);
    pulse(0, 1, 1);
    #1;
    chk("idle_lap_ignored", lap_active, 1'b0);
    chk("idle_clear_run", running, 1'b0);

    // Lone clear in RUN is ignored; start_stop beats lap.
    push_live(1, 3);
    @(negedge CLK); pulse(1, 0, 0);
    repeat (5) @(negedge CLK);
    pulse(0, 0, 1);
    repeat (6) @(negedge CLK);
    #1;
    chk("run_clear_ignored_disp", disp_bcd, bcd_ms(3));
    chk("run_clear_ignored_run", running, 1'b1);
    pulse(1, 1, 0);
    #1;
    chk("ss_over_lap_run", running, 1'b0);
    chk("ss_over_lap_lap", lap_active, 1'b0);
    chk("ss_over_lap_disp", disp_bcd, bcd_ms(3));
    pulse(0, 1, 0);
    #1 chk("pause_lap_ignored", lap_active, 1'b0);

    // Rollover from 23:59:59.999 (prescaler held at 1).
    @(negedge CLK);
    force dut.g_dig[0].u_dig.q = 4'd9;
    force dut.g_dig[1].u_dig.q = 4'd9;
    force dut.g_dig[2].u_dig.q = 4'd9;
    force dut.g_dig[3].u_dig.q = 4'd9;
    force dut.g_dig[4].u_dig.q = 4'd5;
    force dut.g_dig[5].u_dig.q = 4'd9;
    force dut.g_dig[6].u_dig.q = 4'd5;
    force dut.hr_o = 4'd3;
    force dut.hr_t = 4'd2;
    @(negedge CLK);
    release dut.g_dig[0].u_dig.q;
    release dut.g_dig[1].u_dig.q;
    release dut.g_dig[2].u_dig.q;
    release dut.g_dig[3].u_dig.q;
    release dut.g_dig[4].u_dig.q;
    release dut.g_dig[5].u_dig.q;
    release dut.g_dig[6].u_dig.q;
    release dut.hr_o;
    release dut.hr_t;
    #1 chk("preload_disp", disp_bcd, bcd_ms(86399999));
    push(36'h0, 1'b1, 1'b0, 1'b1);
    pulse(1, 0, 0);
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("pre_wrap_tick", ms_tick, 1'b0);
    chk("pre_wrap_roll", rollover, 1'b0);
    @(negedge CLK); #1;
    chk("wrap_tick", ms_tick, 1'b1);
    chk("wrap_roll", rollover, 1'b1);
    chk("wrap_disp", disp_bcd, 36'h0);
    chk("wrap_running", running, 1'b1);
    @(negedge CLK); #1;
    chk("wrap_roll_single", rollover, 1'b0);
    chk("wrap_tick_single", ms_tick, 1'b0);
    drain(10);
    RST_BTN = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
